// File: rtl/gcd_requester_if.sv
// Handshake bundle between the GCD requester, its operand source,
// its result sink and the subtractive GCD core.
`timescale 1ns/1ps
interface gcd_requester_if #(
  parameter int W = 16
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         core_start;
  logic [W-1:0] core_a;
  logic [W-1:0] core_b;
  logic         core_done;
  logic [W-1:0] core_gcd;
  logic         core_rst;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_gcd;
  logic [W-1:0] res_a;
  logic [W-1:0] res_b;
  logic         res_timeout;

  // Requester side: drives the core and the result port.
  modport master (
    input  in_valid, in_a, in_b, core_done, core_gcd, res_ready,
    output in_ready, core_start, core_a, core_b, core_rst,
           res_valid, res_gcd, res_a, res_b, res_timeout
  );

  // Environment side: operand source, core and result sink.
  modport slave (
    output in_valid, in_a, in_b, core_done, core_gcd, res_ready,
    input  in_ready, core_start, core_a, core_b, core_rst,
           res_valid, res_gcd, res_a, res_b, res_timeout
  );
endinterface

// File: rtl/gcd_requester.sv
// Initiator for the subtractive GCD core: queues operand pairs, issues
// them one at a time, returns each result with its operands, and aborts
// a hung core through a dedicated core reset after TIMEOUT cycles.
//
// state     | meaning
// IDLE      | waiting for a queued pair and core_done low
// ISSUE     | core_start high for one cycle, watchdog cleared
// WAIT_DONE | counting cycles until core_done or watchdog expiry
// ABORT     | core_rst held high for two cycles
// RESULT    | res_valid held until accepted
// DRAIN     | waiting for the two-cycle core_done to fall
`timescale 1ns/1ps
module gcd_requester #(
  parameter int W       = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 70000
) (
  input  logic            clk,
  input  logic            rst,
  gcd_requester_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESULT, DRAIN, ABORT} state_t;

  state_t         state;
  logic [W-1:0]   fifo_a [DEPTH];
  logic [W-1:0]   fifo_b [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nxt;
  logic           in_ready_q;
  logic           push;
  logic           pop;
  logic [TW-1:0]  wdog;
  logic           abort_cnt;
  logic           core_start_q;
  logic [W-1:0]   core_a_q;
  logic [W-1:0]   core_b_q;
  logic           core_rst_q;
  logic           res_valid_q;
  logic [W-1:0]   res_gcd_q;
  logic [W-1:0]   res_a_q;
  logic [W-1:0]   res_b_q;
  logic           res_timeout_q;

  assign push = bus.in_valid && in_ready_q;
  assign pop  = (state == IDLE) && (count != '0) && !bus.core_done;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Operand storage; contents need no reset since count guards reads.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= bus.in_a;
      fifo_b[wr_ptr] <= bus.in_b;
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_nxt;
      in_ready_q <= (count_nxt < CW'(DEPTH));
    end
  end

  // Sequencing FSM with all core and result outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wdog          <= '0;
      abort_cnt     <= 1'b0;
      core_start_q  <= 1'b0;
      core_a_q      <= '0;
      core_b_q      <= '0;
      core_rst_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      res_gcd_q     <= '0;
      res_a_q       <= '0;
      res_b_q       <= '0;
      res_timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            core_a_q     <= fifo_a[rd_ptr];
            core_b_q     <= fifo_b[rd_ptr];
            res_a_q      <= fifo_a[rd_ptr];
            res_b_q      <= fifo_b[rd_ptr];
            core_start_q <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          core_start_q <= 1'b0;
          wdog         <= '0;
          state        <= WAIT_DONE;
        end
        WAIT_DONE: begin
          wdog <= wdog + TW'(1);
          // done takes priority over a watchdog expiry in the same cycle
          if (bus.core_done) begin
            res_gcd_q     <= bus.core_gcd;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b1;
            state         <= RESULT;
          end else if (wdog == TW'(TIMEOUT - 1)) begin
            res_gcd_q     <= '0;
            res_timeout_q <= 1'b1;
            res_valid_q   <= 1'b1;
            core_rst_q    <= 1'b1;
            abort_cnt     <= 1'b0;
            state         <= ABORT;
          end
        end
        ABORT: begin
          // the timeout result is already offered and may be taken here
          if (res_valid_q && bus.res_ready) res_valid_q <= 1'b0;
          abort_cnt <= 1'b1;
          if (abort_cnt) begin
            core_rst_q <= 1'b0;
            state      <= RESULT;
          end
        end
        RESULT: begin
          if (!res_valid_q || bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (!bus.core_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.core_start  = core_start_q;
  assign bus.core_a      = core_a_q;
  assign bus.core_b      = core_b_q;
  assign bus.core_rst    = core_rst_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_gcd     = res_gcd_q;
  assign bus.res_a       = res_a_q;
  assign bus.res_b       = res_b_q;
  assign bus.res_timeout = res_timeout_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: behavioural GCD core with random latency and a
// hang mode, a result monitor, and per-scenario tasks that compare the
// observed results with a Euclid-based reference queue.
`timescale 1ns/1ps
module tb_gcd_requester;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
    logic        to;
    int          lat_done;
    int          lat_start;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  res_t exp_q[$];
  res_t obs_q[$];

  int          start_cnt = 0, core_rst_cyc = 0, vcyc = 0, start_while_done = 0;
  int          last_start_cyc = 0, done_cyc = 0, cur_lat_done = 0, cur_lat_start = 0;
  int          last_push_cyc = 0;
  logic [15:0] start_a = '0, start_b = '0;
  logic        prev_done = 1'b0, prev_valid = 1'b0;
  logic        core_hang = 1'b0;

  gcd_requester_if #(.W(16)) bus ();

  gcd_requester #(.W(16), .DEPTH(4), .TIMEOUT(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // Behavioural core: samples operands on start, answers after a random delay
  // with done high for two cycles, or never answers when core_hang is set.
  initial begin : core_model
    bit          busy, hang_op;
    int          lat, done_left;
    logic [15:0] g;
    busy = 0; hang_op = 0; lat = 0; done_left = 0; g = '0;
    bus.core_done = 1'b0;
    bus.core_gcd  = '0;
    forever begin
      @(negedge clk);
      if (rst || bus.core_rst) begin
        busy = 0; done_left = 0; bus.core_done = 1'b0;
      end else begin
        if (done_left > 0) begin
          done_left--;
          bus.core_done = (done_left != 0);
        end else if (busy && !hang_op) begin
          if (lat == 0) begin
            bus.core_done = 1'b1; bus.core_gcd = g; done_left = 2; busy = 0;
          end else lat--;
        end
        if (bus.core_start && !busy && done_left == 0) begin
          g = ref_gcd(bus.core_a, bus.core_b);
          lat = $urandom_range(0, 5);
          hang_op = core_hang;
          busy = 1;
        end
      end
    end
  end

  // Monitor: counts pulses and captures each accepted result.
  initial begin : monitor
    forever begin
      @(negedge clk); #1;
      if (bus.core_start) begin
        start_cnt++; last_start_cyc = cyc; start_a = bus.core_a; start_b = bus.core_b;
        if (bus.core_done) start_while_done++;
      end
      if (bus.core_rst) core_rst_cyc++;
      if (bus.res_valid) vcyc++;
      if (bus.core_done && !prev_done) done_cyc = cyc;
      if (bus.res_valid && !prev_valid) begin
        cur_lat_done = cyc - done_cyc; cur_lat_start = cyc - last_start_cyc;
      end
      if (bus.res_valid && bus.res_ready && !rst)
        obs_q.push_back('{bus.res_a, bus.res_b, bus.res_gcd, bus.res_timeout,
                          cur_lat_done, cur_lat_start});
      prev_done = bus.core_done; prev_valid = bus.res_valid;
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic to);
    int n;
    n = 0;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL push_stall: in_ready=%0b after %0d cycles, required 1", bus.in_ready, n);
    end else begin
      last_push_cyc = cyc;
      exp_q.push_back('{a, b, to ? 16'd0 : ref_gcd(a, b), to, 1, 21});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int k;
    k = 0;
    while (obs_q.size() < n && k < 800) begin @(negedge clk); k++; end
    if (obs_q.size() < n) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_results: got %0d results, required %0d", obs_q.size(), n);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = 16'd9; bus.in_b = 16'd3;
    @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, bus.core_start, bus.core_a, bus.core_b, bus.core_rst, bus.res_valid,
         bus.res_gcd, bus.res_a, bus.res_b, bus.res_timeout} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 48'd0, 1'b0})
      begin n_fail++; $display("FAIL reset_values: in_ready=%0b start=%0b core_a=%0d res_valid=%0b res_gcd=%0d, required 1/0/0/0/0",
                      bus.in_ready, bus.core_start, bus.core_a, bus.res_valid, bus.res_gcd); end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (start_cnt !== 0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_push_ignored: starts=%0d in_ready=%0b, required 0/1", start_cnt, bus.in_ready);
    end
  endtask

  task automatic test_basic();
    int s0, v0;
    res_t e, o;
    bus.res_ready = 1'b1;
    s0 = start_cnt; v0 = vcyc;
    push(16'd48, 16'd18, 1'b0);
    wait_results(1);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (start_cnt - s0 !== 1) begin n_fail++; $display("FAIL basic_one_start: got %0d starts, required 1", start_cnt - s0); end
    n_cmp++;
    if (last_start_cyc !== last_push_cyc + 2) begin
      n_fail++; $display("FAIL basic_start_latency: start at %0d, required %0d", last_start_cyc, last_push_cyc + 2);
    end
    n_cmp++;
    if (start_a !== 16'd48 || start_b !== 16'd18) begin
      n_fail++; $display("FAIL basic_core_operands: a=%0d b=%0d, required 48 18", start_a, start_b);
    end
    n_cmp++;
    if (vcyc - v0 !== 1) begin n_fail++; $display("FAIL basic_one_valid: %0d valid cycles, required 1", vcyc - v0); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if ({o.a, o.b, o.g, o.to} !== {e.a, e.b, e.g, e.to} || o.g !== 16'd6) begin
        n_fail++; $display("FAIL basic_result: got (%0d,%0d)->%0d to=%0b, required (%0d,%0d)->%0d to=%0b",
                           o.a, o.b, o.g, o.to, e.a, e.b, e.g, e.to);
      end
      n_cmp++;
      if (o.lat_done !== 1) begin n_fail++; $display("FAIL basic_done_latency: got %0d, required 1", o.lat_done); end
    end
  endtask

  task automatic test_back_to_back();
    int sw0;
    res_t e, o;
    bus.res_ready = 1'b1;
    sw0 = start_while_done;
    push(16'd0, 16'd0, 1'b0);
    push(16'd7, 16'd0, 1'b0);
    wait_results(2);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (start_while_done !== sw0) begin
      n_fail++; $display("FAIL b2b_start_during_done: %0d starts with core_done high, required 0", start_while_done - sw0);
    end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if ({o.a, o.b, o.g, o.to} !== {e.a, e.b, e.g, e.to}) begin
        n_fail++; $display("FAIL b2b_result: got (%0d,%0d)->%0d, required (%0d,%0d)->%0d", o.a, o.b, o.g, e.a, e.b, e.g);
      end
    end
    n_cmp++;
    if (obs_q.size() !== 0 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL b2b_count: leftover obs=%0d exp=%0d, required 0 0", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_fill_hold_wrap();
    logic [15:0] pa [5];
    logic [15:0] pb [5];
    int   i, s0, guard;
    logic prev_rdy;
    res_t e, o;
    for (int k = 0; k < 5; k++) begin
      pa[k] = 16'($urandom_range(1, 500)); pb[k] = 16'($urandom_range(1, 500));
    end
    bus.res_ready = 1'b0;
    push(16'd35, 16'd21, 1'b0);
    guard = 0;
    while (!bus.res_valid && guard < 100) begin @(negedge clk); guard++; end
    s0 = start_cnt; i = 0; prev_rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.in_valid && prev_rdy) begin
        exp_q.push_back('{pa[i], pb[i], ref_gcd(pa[i], pb[i]), 1'b0, 1, 21}); i++;
      end
      n_cmp++;
      if (bus.res_valid !== 1'b1 || bus.res_gcd !== 16'd7 || bus.res_a !== 16'd35 || bus.res_b !== 16'd21) begin
        n_fail++; $display("FAIL hold_stable: cycle %0d valid=%0b gcd=%0d, required 1 7", c, bus.res_valid, bus.res_gcd);
      end
      if (i < 5) begin bus.in_valid = 1'b1; bus.in_a = pa[i]; bus.in_b = pb[i]; end
      else bus.in_valid = 1'b0;
      prev_rdy = bus.in_ready;
    end
    n_cmp++;
    if (start_cnt !== s0) begin n_fail++; $display("FAIL hold_no_start: %0d starts, required 0", start_cnt - s0); end
    n_cmp++;
    if (i !== 4 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL fifo_full: accepted %0d in_ready=%0b, required 4 0", i, bus.in_ready);
    end
    bus.res_ready = 1'b1;
    guard = 0;
    while (i < 5 && guard < 200) begin
      @(negedge clk); guard++;
      if (bus.in_valid && prev_rdy) begin
        exp_q.push_back('{pa[i], pb[i], ref_gcd(pa[i], pb[i]), 1'b0, 1, 21}); i++;
      end
      if (i >= 5) bus.in_valid = 1'b0;
      prev_rdy = bus.in_ready;
    end
    bus.in_valid = 1'b0;
    wait_results(6);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL fifo_recover: in_ready=%0b, required 1", bus.in_ready); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if ({o.a, o.b, o.g, o.to} !== {e.a, e.b, e.g, e.to}) begin
        n_fail++; $display("FAIL wrap_order: got (%0d,%0d)->%0d, required (%0d,%0d)->%0d", o.a, o.b, o.g, e.a, e.b, e.g);
      end
    end
    n_cmp++;
    if (obs_q.size() !== 0 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL wrap_count: leftover obs=%0d exp=%0d, required 0 0", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int r0, guard;
    res_t e, o;
    bus.res_ready = 1'b1;
    core_hang = 1'b1;
    r0 = core_rst_cyc;
    push(16'd90, 16'd60, 1'b1);
    push(16'd27, 16'd36, 1'b0);
    guard = 0;
    while (core_rst_cyc == r0 && guard < 200) begin @(negedge clk); guard++; end
    core_hang = 1'b0;
    wait_results(2);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (core_rst_cyc - r0 !== 2) begin n_fail++; $display("FAIL abort_core_rst: high %0d cycles, required 2", core_rst_cyc - r0); end
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if ({o.a, o.b, o.g, o.to} !== {e.a, e.b, e.g, e.to}) begin
        n_fail++; $display("FAIL timeout_result: got (%0d,%0d)->%0d to=%0b, required (%0d,%0d)->%0d to=%0b",
                           o.a, o.b, o.g, o.to, e.a, e.b, e.g, e.to);
      end
      if (e.to) begin
        n_cmp++;
        if (o.lat_start !== 21) begin
          n_fail++; $display("FAIL timeout_latency: valid %0d cycles after start, required 21", o.lat_start);
        end
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 16;
    logic [15:0] pa [N];
    logic [15:0] pb [N];
    int   i, guard;
    logic prev_rdy;
    res_t e, o;
    for (int k = 0; k < N; k++) begin
      pa[k] = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 200) * $urandom_range(1, 50));
      pb[k] = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 200) * $urandom_range(1, 50));
    end
    i = 0; prev_rdy = 1'b0; guard = 0;
    while (i < N && guard < 3000) begin
      @(negedge clk); guard++;
      if (bus.in_valid && prev_rdy) begin
        exp_q.push_back('{pa[i], pb[i], ref_gcd(pa[i], pb[i]), 1'b0, 1, 21}); i++;
      end
      bus.res_ready = 1'($urandom_range(0, 1));
      if (i < N && $urandom_range(0, 3) != 0) begin bus.in_valid = 1'b1; bus.in_a = pa[i]; bus.in_b = pb[i]; end
      else bus.in_valid = 1'b0;
      prev_rdy = bus.in_ready;
    end
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b1;
    wait_results(N);
    repeat (4) @(negedge clk);
    while (exp_q.size() != 0 && obs_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++;
      if ({o.a, o.b, o.g, o.to} !== {e.a, e.b, e.g, e.to} || o.lat_done !== 1) begin
        n_fail++; $display("FAIL random_result: got (%0d,%0d)->%0d to=%0b lat=%0d, required (%0d,%0d)->%0d to=0 lat=1",
                           o.a, o.b, o.g, o.to, o.lat_done, e.a, e.b, e.g);
      end
    end
    n_cmp++;
    if (obs_q.size() !== 0 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL random_count: leftover obs=%0d exp=%0d, required 0 0", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_op();
    int s0;
    bus.res_ready = 1'b1;
    core_hang = 1'b1;
    push(16'd12, 16'd8, 1'b0);
    push(16'd15, 16'd10, 1'b0);
    push(16'd21, 16'd14, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.core_start, bus.core_a, bus.core_b, bus.core_rst, bus.res_valid,
         bus.res_gcd, bus.res_a, bus.res_b, bus.res_timeout} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 48'd0, 1'b0})
      begin n_fail++; $display("FAIL async_reset: in_ready=%0b core_a=%0d core_b=%0d res_a=%0d, required 1 0 0 0",
                      bus.in_ready, bus.core_a, bus.core_b, bus.res_a); end
    @(negedge clk);
    #2 rst = 1'b0;
    core_hang = 1'b0;
    exp_q.delete();
    s0 = start_cnt;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (start_cnt !== s0 || obs_q.size() !== 0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_flush: starts=%0d results=%0d in_ready=%0b, required 0 0 1",
                         start_cnt - s0, obs_q.size(), bus.in_ready);
    end
  endtask

  initial begin : global_bound
    #2ms;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin : main
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    repeat (3) @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_fill_hold_wrap();
    repeat (3) @(negedge clk);
    test_timeout();
    repeat (3) @(negedge clk);
    test_random();
    repeat (3) @(negedge clk);
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
